// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated register mux.
//   arb_mode_e : arbitration policy selector (fixed priority / round-robin)
//   ch_w()     : width of a channel index, never less than 1 bit
package arb_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Number of bits needed to encode a channel index, at least 1.
    function automatic int ch_w(int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_mux_reg_arb.sv
// Combinational N-way arbiter.
//   req       : per-channel requests
//   ptr       : round-robin start position (ignored in fixed-priority mode)
//   grant     : one-hot grant, zero when nothing requests
//   grant_idx : binary index of the granted channel (0 when nothing requests)
// The requests are duplicated side by side and scanned upward from ptr, so
// the first hit at or after ptr is found without an explicit wrap step.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 1,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic [2*NUM_CH-1:0] req2;
    logic [CH_W-1:0]     start;
    logic                found;

    assign req2  = {req, req};
    // Fixed priority is just a scan that always starts at channel 0.
    assign start = (MODE == ARB_RR) ? ptr : '0;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < 2*NUM_CH; j++) begin
            if (!found && (j >= int'(start)) && req2[j]) begin
                found                = 1'b1;
                grant[j % NUM_CH]    = 1'b1;
                grant_idx            = CH_W'(j % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel, WIDTH-bit arbitrated mux with a single registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-channel request
//   in_data    : per-channel payload
//   in_ready   : per-channel accept (one-hot or zero)
//   out_valid  : output register holds a word
//   out_data   : registered payload
//   out_ch     : channel that supplied out_data
//   out_ready  : downstream accept
// The output register refills whenever it is empty or being drained in the
// same cycle, so back-to-back transfers need no bubble while out_ready is high.
module arb_mux_reg
    import arb_mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int RR_MODE = 1,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH-1:0][WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [CH_W-1:0]              out_ch,
    input  logic                         out_ready
);

    localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic                         out_valid_reg;
    logic [WIDTH-1:0]             out_data_reg;
    logic [CH_W-1:0]              out_ch_reg;
    logic [CH_W-1:0]              rr_ptr_reg;
    logic [CH_W-1:0]              rr_ptr_next;

    logic [NUM_CH-1:0]            req;
    logic [NUM_CH-1:0]            grant;
    logic [CH_W-1:0]              grant_idx;
    logic                         load_en;
    logic                         xfer;
    logic [NUM_CH-1:0][WIDTH-1:0] masked_data;
    logic [WIDTH-1:0]             sel_data;

    // Masking requests with rst_n keeps every in_ready low while reset is held,
    // even though an empty output register would otherwise accept.
    assign req = in_valid & {NUM_CH{rst_n}};

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load_en  = !out_valid_reg || out_ready;
    assign in_ready = grant & {NUM_CH{load_en}};
    // A grant only exists where a request is valid, so any ready bit is a transfer.
    assign xfer     = |in_ready;

    // AND-OR select: the grant is one-hot, so at most one term is non-zero.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
        assign masked_data[gi] = in_data[gi] & {WIDTH{grant[gi]}};
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data = sel_data | masked_data[i];
        end
    end

    if (MODE == ARB_RR) begin : g_rr_ptr
        assign rr_ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0
                                                             : grant_idx + CH_W'(1);
    end else begin : g_fixed_ptr
        assign rr_ptr_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= sel_data;
                out_ch_reg    <= grant_idx;
                rr_ptr_reg    <= rr_ptr_next;
            end else begin
                // Draining with nothing to refill: payload and index are kept.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: a round-robin 4x32 instance driven by hand sequences
// and random traffic against a scoreboard model, a fixed-priority 4x32
// instance driven from a vector table, and a 2x64 round-robin instance.
module tb_arb_mux_reg;

    logic clk;
    logic rst_n;

    // Round-robin, 4 x 32
    logic [3:0]       rv;
    logic [3:0][31:0] rd;
    logic [3:0]       rrdy;
    logic             ov;
    logic [31:0]      od;
    logic [1:0]       och;
    logic             ordy;

    // Fixed priority, 4 x 32
    logic [3:0]       fv;
    logic [3:0][31:0] fd;
    logic [3:0]       frdy;
    logic             fov;
    logic [31:0]      fod;
    logic [1:0]       foch;
    logic             fordy;

    // Round-robin, 2 x 64
    logic [1:0]       wv;
    logic [1:0][63:0] wd;
    logic [1:0]       wrdy;
    logic             wov;
    logic [63:0]      wod;
    logic [0:0]       woch;
    logic             wordy;

    int n_checks;
    int n_err;

    // Scoreboard model state for the round-robin 4x32 instance.
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_ch;

    arb_mux_reg #(.NUM_CH(4), .WIDTH(32), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_data(rd), .in_ready(rrdy),
        .out_valid(ov), .out_data(od), .out_ch(och), .out_ready(ordy)
    );

    arb_mux_reg #(.NUM_CH(4), .WIDTH(32), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(fv), .in_data(fd), .in_ready(frdy),
        .out_valid(fov), .out_data(fod), .out_ch(foch), .out_ready(fordy)
    );

    arb_mux_reg #(.NUM_CH(2), .WIDTH(64), .RR_MODE(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(wv), .in_data(wd), .in_ready(wrdy),
        .out_valid(wov), .out_data(wod), .out_ch(woch), .out_ready(wordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First requesting channel at or after ptr, walking round the ring; -1 if none.
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
    endtask

    // One clock of the round-robin instance: inputs already applied by caller.
    task automatic rr_cycle(input string tag, output logic [3:0] acc);
        int   g;
        logic load;
        load = !m_valid || ordy;
        g    = pick(rv, m_ptr);
        acc  = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        #1;
        chk({tag, ".in_ready"}, 64'(rrdy), 64'(acc));
        @(posedge clk);
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = rd[g];
                m_ch    = g;
                m_ptr   = (g + 1) % 4;
                $display("%s: accept ch%0d data %08h", tag, g, m_data);
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk({tag, ".out_valid"}, 64'(ov), 64'(m_valid));
        chk({tag, ".out_data"}, 64'(od), 64'(m_data));
        chk({tag, ".out_ch"}, 64'(och), 64'(m_ch));
    endtask

    typedef struct {
        logic [3:0]  v;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  ch;
        logic [31:0] d;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [3:0]  acc;
        logic [63:0] ew;

        n_checks = 0;
        n_err    = 0;
        model_reset();

        rst_n = 1'b0;
        rv = 4'hF;  ordy = 1'b1;
        fv = 4'h0;  fordy = 1'b1;
        wv = 2'b00; wordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 32'hA0 + 32'(i);
            fd[i] = 32'hF0 + 32'(i);
        end
        wd[0] = 64'hDEADBEEF_CAFEF00D;
        wd[1] = 64'h01234567_89ABCDEF;

        // Requests during reset must not be accepted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(rrdy), 64'h0);
        chk("rst.out_valid", 64'(ov), 64'h0);
        chk("rst.out_data", 64'(od), 64'h0);
        chk("rst.out_ch", 64'(och), 64'h0);
        chk("rst.fx_out_valid", 64'(fov), 64'h0);
        chk("rst.w_out_data", wod, 64'h0);

        rv = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) rr_cycle("idle", acc);

        // Round-robin burst over all four channels.
        rv = 4'hF;
        for (int k = 0; k < 5; k++) begin
            rr_cycle("burst", acc);
            chk("burst.seq_ch", 64'(och), 64'(k % 4));
        end

        // Load one word, then stall for three cycles with channel 2 waiting.
        rv = 4'b0001; rd[0] = 32'h11;
        rr_cycle("load", acc);
        rv = 4'b0100; rd[2] = 32'h22; ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rr_cycle("stall", acc);
            chk("stall.hold_data", 64'(od), 64'h11);
            chk("stall.no_ready", 64'(acc), 64'h0);
        end
        ordy = 1'b1;
        rr_cycle("refill", acc);
        chk("refill.ready", 64'(acc), 64'b0100);
        chk("refill.data", 64'(od), 64'h22);
        chk("refill.no_bubble", 64'(ov), 64'h1);

        // Asynchronous reset in the middle of a burst.
        rv = 4'hF;
        rr_cycle("areset_pre", acc);
        rr_cycle("areset_pre", acc);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset.out_valid", 64'(ov), 64'h0);
        chk("areset.in_ready", 64'(rrdy), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rr_cycle("areset_post", acc);
        chk("areset.ptr_zero", 64'(och), 64'h0);
        rv = 4'h0;
        rr_cycle("drain", acc);

        // Fixed priority vectors: channels 1 and 3 contend, channel 3 starves.
        vt[0] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hF1};
        vt[1] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hF1};
        vt[2] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hF1};
        vt[3] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hF3};
        vt[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hF3};
        vt[5] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hF0};
        vt[6] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hF0};
        vt[7] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hF1};
        for (int i = 0; i < 8; i++) begin
            fv    = vt[i].v;
            fordy = vt[i].ordy;
            #1;
            chk($sformatf("fx%0d.in_ready", i), 64'(frdy), 64'(vt[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("fx%0d.out_valid", i), 64'(fov), 64'(vt[i].ov));
            chk($sformatf("fx%0d.out_ch", i), 64'(foch), 64'(vt[i].ch));
            chk($sformatf("fx%0d.out_data", i), 64'(fod), 64'(vt[i].d));
            $display("fx%0d: valid %b ready %b -> ch%0d data %08h", i, fv, frdy, foch, fod);
        end
        fv = 4'h0; fordy = 1'b1;

        // Two-channel, 64-bit instance alternating between its channels.
        wv = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wide.in_ready", 64'(wrdy), (k % 2 == 0) ? 64'b01 : 64'b10);
            @(posedge clk);
            #1;
            ew = wd[k % 2];
            chk("wide.out_valid", 64'(wov), 64'h1);
            chk("wide.out_ch", 64'(woch), 64'(k % 2));
            chk("wide.out_data", wod, ew);
            $display("wide: accept ch%0d data %016h", woch, wod);
        end
        wv = 2'b00;

        // Random traffic; each producer holds its word until accepted.
        acc = 4'h0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] || acc[i]) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    rd[i] = $urandom;
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            rr_cycle("rand", acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
